// File: rtl/mux2_pattern_gen.sv
// Stimulus and check stage for a 2:1 mux. Steps {sel,d1,d0} through all eight
// combinations, holds each for DWELL cycles, and counts mismatches on z_in.
module mux2_pattern_gen #(
    parameter int DWELL = 36,
    parameter int CNT_W = 6,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             loop,
    input  logic             z_in,
    output logic             d0,
    output logic             d1,
    output logic             sel,
    output logic             busy,
    output logic             done,
    output logic [2:0]       vec_idx,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_DWELL = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] DWELL_ONE  = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;
    localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_dwell;
    logic [2:0]         r_vec_idx;
    logic               r_d0;
    logic               r_d1;
    logic               r_sel;
    logic               r_busy;
    logic               r_done;
    logic [ERR_W-1:0]   r_err_cnt;

    logic               w_expected;
    logic               w_mismatch;
    logic               w_last_cycle;
    logic [2:0]         w_next_idx;

    // The check uses the vector currently on the pins, so it always matches
    // what the mux has been settling on for the whole dwell.
    assign w_expected   = r_sel ? r_d1 : r_d0;
    assign w_mismatch   = (z_in != w_expected);
    assign w_last_cycle = (r_dwell == LAST_DWELL);
    assign w_next_idx   = r_vec_idx + 3'd1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dwell   <= '0;
            r_vec_idx <= 3'd0;
            r_d0      <= 1'b0;
            r_d1      <= 1'b0;
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state             <= S_RUN;
                        r_dwell             <= '0;
                        r_vec_idx           <= 3'd0;
                        r_err_cnt           <= '0;
                        r_busy              <= 1'b1;
                        {r_sel, r_d1, r_d0} <= 3'b000;
                    end
                end

                S_RUN: begin
                    if (w_last_cycle) begin
                        r_dwell <= '0;
                        if (w_mismatch && (r_err_cnt != ERR_MAX)) begin
                            r_err_cnt <= r_err_cnt + ERR_ONE;
                        end
                        if (r_vec_idx != 3'd7) begin
                            r_vec_idx           <= w_next_idx;
                            {r_sel, r_d1, r_d0} <= w_next_idx;
                        end else if (loop) begin
                            r_vec_idx           <= 3'd0;
                            {r_sel, r_d1, r_d0} <= 3'b000;
                        end else begin
                            // vec_idx keeps 7 so the final position stays visible in IDLE.
                            r_state             <= S_DONE;
                            r_busy              <= 1'b0;
                            r_done              <= 1'b1;
                            {r_sel, r_d1, r_d0} <= 3'b000;
                        end
                    end else begin
                        r_dwell <= r_dwell + DWELL_ONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign d0       = r_d0;
    assign d1       = r_d1;
    assign sel      = r_sel;
    assign busy     = r_busy;
    assign done     = r_done;
    assign vec_idx  = r_vec_idx;
    assign err_cnt  = r_err_cnt;
    assign err_flag = (r_err_cnt != '0);

endmodule

// File: tb/tb_mux2_pattern_gen.sv
// Self-checking bench for mux2_pattern_gen: a DWELL=36 instance with a
// cycle-level scoreboard and a DWELL=1 instance for the single-cycle case.
module tb_mux2_pattern_gen;

    localparam int DW_A  = 36;
    localparam int ERR_W = 4;

    typedef struct {
        logic [2:0] idx;
        logic       d0;
        logic       d1;
        logic       sel;
    } vec_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] idx;
        logic       sel;
        logic       d1;
        logic       d0;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic loop;
    int   mode;  // 0 = correct mux, 1 = z stuck at 0, 2 = inverted mux

    logic a_d0, a_d1, a_sel, a_busy, a_done, a_err_flag, a_z;
    logic [2:0] a_idx;
    logic [ERR_W-1:0] a_err;
    logic b_d0, b_d1, b_sel, b_busy, b_done, b_err_flag, b_z;
    logic [2:0] b_idx;
    logic [ERR_W-1:0] b_err;

    vec_t tbl[8];
    obs_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    assign a_z = (mode == 0) ? (a_sel ? a_d1 : a_d0) :
                 (mode == 1) ? 1'b0 : ~(a_sel ? a_d1 : a_d0);
    assign b_z = b_sel ? b_d1 : b_d0;

    mux2_pattern_gen #(.DWELL(DW_A), .CNT_W(6), .ERR_W(ERR_W)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .z_in(a_z),
        .d0(a_d0), .d1(a_d1), .sel(a_sel), .busy(a_busy), .done(a_done),
        .vec_idx(a_idx), .err_cnt(a_err), .err_flag(a_err_flag)
    );

    mux2_pattern_gen #(.DWELL(1), .CNT_W(6), .ERR_W(ERR_W)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .z_in(b_z),
        .d0(b_d0), .d1(b_d1), .sel(b_sel), .busy(b_busy), .done(b_done),
        .vec_idx(b_idx), .err_cnt(b_err), .err_flag(b_err_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, scoreboard popped per cycle.
    task automatic tick();
        obs_t obs, exp;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            obs = '{busy: a_busy, done: a_done, idx: a_idx, sel: a_sel, d1: a_d1, d0: a_d0};
            check("sb_cycle", 32'(obs), 32'(exp));
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_busy"}, 32'(a_busy), 0);
        check({tag, "_done"}, 32'(a_done), 0);
        check({tag, "_idx"},  32'(a_idx), 0);
        check({tag, "_pins"}, 32'({a_sel, a_d1, a_d0}), 0);
        check({tag, "_err"},  32'(a_err), 0);
        check({tag, "_flag"}, 32'(a_err_flag), 0);
    endtask

    // Single pass on instance A; the whole expected waveform comes from the table.
    task automatic run_single(input int m);
        mode  = m;
        loop  = 1'b0;
        start = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c < DW_A; c++) begin
                sb.push_back('{busy: 1'b1, done: 1'b0, idx: tbl[v].idx,
                               sel: tbl[v].sel, d1: tbl[v].d1, d0: tbl[v].d0});
            end
        end
        sb.push_back('{busy: 1'b0, done: 1'b1, idx: 3'd7, sel: 1'b0, d1: 1'b0, d0: 1'b0});
        sb.push_back('{busy: 1'b0, done: 1'b0, idx: 3'd7, sel: 1'b0, d1: 1'b0, d0: 1'b0});
        tick();
        start = 1'b0;
        while (sb.size() > 0) tick();
    endtask

    initial begin
        tbl[0] = '{3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{3'd2, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{3'd3, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{3'd4, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{3'd5, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{3'd6, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{3'd7, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        loop  = 1'b0;
        mode  = 0;
        repeat (3) tick();
        check_a_zero("rst");
        check("rst_b_busy", 32'(b_busy), 0);
        check("rst_b_idx", 32'(b_idx), 0);
        rst_n = 1'b1;
        tick();

        // Single pass, correct mux.
        run_single(0);
        check("good_err", 32'(a_err), 0);
        check("good_flag", 32'(a_err_flag), 0);

        // z stuck at 0: idx 1, 3, 6, 7 mismatch.
        run_single(1);
        check("stuck_err", 32'(a_err), 4);
        check("stuck_flag", 32'(a_err_flag), 1);
        repeat (5) tick();
        check("stuck_hold_err", 32'(a_err), 4);
        check("stuck_hold_idx", 32'(a_idx), 7);
        check("stuck_hold_busy", 32'(a_busy), 0);

        // Looping with an inverted mux: saturation, then loop dropped mid-pass.
        mode  = 2;
        loop  = 1'b1;
        start = 1'b1;
        tick();                                    // cycle 1
        start = 1'b0;
        check("loop_err_clr", 32'(a_err), 0);
        repeat (288) tick();                       // cycle 289
        check("loop_p1_err", 32'(a_err), 8);
        check("loop_p2_idx", 32'(a_idx), 0);
        check("loop_p2_busy", 32'(a_busy), 1);
        repeat (251) tick();                       // cycle 540
        check("loop_err14", 32'(a_err), 14);
        tick();                                    // cycle 541
        check("loop_err15", 32'(a_err), 15);
        repeat (36) tick();                        // cycle 577
        check("loop_sat", 32'(a_err), 15);
        check("loop_p3_idx", 32'(a_idx), 0);
        repeat (108) tick();                       // cycle 685
        check("loop_p3_idx3", 32'(a_idx), 3);
        loop = 1'b0;
        repeat (179) tick();                       // cycle 864
        check("loop_last_busy", 32'({a_busy, a_done, a_idx}), 32'({1'b1, 1'b0, 3'd7}));
        tick();
        check("loop_done", 32'({a_busy, a_done}), 32'({1'b0, 1'b1}));
        tick();
        check("loop_idle", 32'({a_busy, a_done, a_idx, a_err}), 32'({1'b0, 1'b0, 3'd7, 4'd15}));

        // Start held through RUN and DONE.
        mode  = 2;
        start = 1'b1;
        tick();                                    // cycle 1
        check("hold_busy", 32'(a_busy), 1);
        check("hold_err_clr", 32'(a_err), 0);
        repeat (100) tick();                       // cycle 101
        check("hold_idx", 32'({a_busy, a_idx}), 32'({1'b1, 3'd2}));
        repeat (187) tick();                       // cycle 288
        check("hold_last", 32'({a_busy, a_idx, a_err}), 32'({1'b1, 3'd7, 4'd7}));
        tick();
        check("hold_done", 32'({a_busy, a_done, a_err}), 32'({1'b0, 1'b1, 4'd8}));
        tick();
        check("hold_idle", 32'({a_busy, a_done, a_idx, a_err}), 32'({1'b0, 1'b0, 3'd7, 4'd8}));
        tick();
        check("hold_restart", 32'({a_busy, a_idx, a_err}), 32'({1'b1, 3'd0, 4'd0}));
        start = 1'b0;

        // Reset in the middle of a run.
        repeat (98) tick();
        check("mid_busy", 32'(a_busy), 1);
        rst_n = 1'b0;
        tick();
        check_a_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(a_busy), 0);
        check("post_rst_done", 32'(a_done), 0);
        run_single(0);
        check("post_rst_err", 32'(a_err), 0);

        // DWELL=1 instance: one vector per cycle.
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("d1_idx", 32'(b_idx), 32'(tbl[i].idx));
            check("d1_pins", 32'({b_sel, b_d1, b_d0}), 32'({tbl[i].sel, tbl[i].d1, tbl[i].d0}));
            check("d1_busy", 32'({b_busy, b_done}), 32'({1'b1, 1'b0}));
            tick();
        end
        check("d1_done", 32'({b_busy, b_done}), 32'({1'b0, 1'b1}));
        check("d1_err", 32'({b_err_flag, b_err}), 0);
        tick();
        check("d1_idle", 32'({b_busy, b_done, b_idx}), 32'({1'b0, 1'b0, 3'd7}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_pattern_gen.md
Name: mux2_pattern_gen

Overview:
- Upstream stimulus and check stage for mux2.
- On a start request it drives d0/d1/sel through all 8 input combinations, holding each for a programmable number of cycles.
- It samples the mux output z returned on z_in and counts mismatches against the expected value (sel ? d1 : d0).
- Provides a start/busy/done handshake so a controller or bench can run single-pass or continuous self-checks of mux2.

Parameters:
DWELL, 36, clock cycles each vector is held; legal range 1..2**CNT_W.
CNT_W, 6, dwell counter width.
ERR_W, 4, mismatch counter width; the counter saturates at 2**ERR_W-1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  level-sampled run request; honoured only in IDLE.
loop  in  1  1 = repeat the 8-vector pass continuously; 0 = single pass.
z_in  in  1  mux2 output z, fed back for checking.
d0  out  1  mux2 d0 drive.
d1  out  1  mux2 d1 drive.
sel  out  1  mux2 sel drive.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse when a pass ends with loop=0.
vec_idx  out  3  current vector index.
err_cnt  out  ERR_W  saturating mismatch count.
err_flag  out  1  err_cnt != 0 (combinational from err_cnt).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising clk edge.
- Reset values: while rst_n=0 at a clk edge, all outputs go to 0 at that edge.
  - Covers d0, d1, sel, busy, done, vec_idx, err_cnt; FSM goes to IDLE and the dwell counter to 0.
  - Reset mid-RUN aborts immediately. No done pulse; err_cnt is cleared.
- Registered outputs: all outputs except err_flag are registered.
- Vector mapping: {sel,d1,d0} = vec_idx[2:0]. Order is 000,001,…,111, so idx1 is d0=1; idx4 is sel=1 with d0=d1=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - d0/d1/sel = 0, busy = 0.
    - If start=1 at an edge: go to RUN, vec_idx=0, dwell=0, err_cnt=0. busy and vector 0 are visible the next cycle (1-cycle latency).
  - RUN:
    - d0/d1/sel = vec_idx bits. dwell increments each cycle.
    - When dwell==DWELL-1:
      - Compare z_in with expected = sel ? d1 : d0. On mismatch, err_cnt+1, saturating.
      - dwell returns to 0.
      - If vec_idx<7: vec_idx+1.
      - If vec_idx==7 and loop=1: vec_idx wraps to 0, stay in RUN.
      - If vec_idx==7 and loop=0: go to DONE.
    - Each vector is presented exactly DWELL cycles. z_in is checked only on the last cycle of each dwell, allowing for mux/path settling.
    - start is ignored in RUN.
    - loop is sampled only at the idx7 end-of-dwell edge; changes mid-pass take effect there.
  - DONE:
    - done=1, busy=0, d0/d1/sel=0 for exactly one cycle, then IDLE.
    - start in DONE is ignored.
- Single-pass timing: busy is high for 8*DWELL cycles; done rises in the cycle immediately after the last busy cycle.
- err_cnt and vec_idx hold their final values in IDLE until the next accepted start or reset.
- DWELL=1: vector changes every cycle and every cycle is a check cycle.

Test Plan:
1. Reset: run with DWELL=36; assert rst_n=0 for 2 cycles at cycle 100 → at the next edge all outputs are 0, no done pulse, FSM in IDLE; a new start runs normally.
2. Single pass, z_in driven by a correct mux2 model, start pulsed at cycle k → vectors 000..111 each held 36 cycles from k+1; busy high cycles k+1..k+288; done=1 only at k+289; err_cnt=0, err_flag=0.
3. z_in stuck at 0, single pass → mismatches on idx 1, 3, 6, 7 only; err_cnt=4, err_flag=1 after done; holds 4 in IDLE.
4. loop=1, z_in = ~expected → err_cnt reaches 8 after pass 1 and saturates at 15 during pass 2. Drop loop during pass 3 at idx3 → pass completes through idx7, then one done pulse.
5. Start held high during RUN and during DONE → no restart or reset of vec_idx/err_cnt mid-pass. After DONE→IDLE with start still high, a new run begins with err_cnt cleared.
6. DWELL=1 build, correct z_in → vec_idx 0..7 on consecutive cycles; busy 8 cycles; done pulse on the 9th cycle after start; err_cnt=0.
